// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Streams a preamble plus configuration words into a serial
//               ccff chain and checks the preamble returning at the tail.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int          CHAIN_LEN = 64,
    parameter int          WORD_W    = 8,
    parameter int          PRE_LEN   = 8,
    parameter logic [31:0] PREAMBLE  = 32'h000000A5
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int c_TOTAL = PRE_LEN + CHAIN_LEN;
    localparam int c_N_W   = $clog2(c_TOTAL + 1);
    localparam int c_R_W   = $clog2(CHAIN_LEN + 1);
    localparam int c_C_W   = $clog2(WORD_W + 1);

    localparam logic [c_N_W-1:0] c_N_PRE_END = c_N_W'(PRE_LEN - 1);
    localparam logic [c_N_W-1:0] c_N_LAST    = c_N_W'(c_TOTAL - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PRE  = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_N_W-1:0]  r_n;
    logic [WORD_W-1:0] r_buf;     // bits queued behind the one on ccff_head
    logic [c_C_W-1:0]  r_cnt;     // buffered bits, including the one on ccff_head
    logic [c_R_W-1:0]  r_rem;     // chain bits not yet taken from cfg_data
    logic              r_head;
    logic              r_shift_en;
    logic              r_error;

    logic              w_pre_end;
    logic              w_last;
    logic              w_buf_free;
    logic              w_accept;
    logic [c_C_W-1:0]  w_take;
    logic [4:0]        w_pre_idx;
    logic [4:0]        w_cmp_idx;
    logic              w_cmp_en;
    logic              w_mismatch;

    assign w_pre_end  = (r_state == c_ST_PRE) && (r_n == c_N_PRE_END);
    assign w_last     = (r_state == c_ST_LOAD) && r_shift_en && (r_n == c_N_LAST);
    assign w_buf_free = (r_cnt == '0) || ((r_cnt == c_C_W'(1)) && r_shift_en);
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_pre_idx  = 5'(32'(r_n) + 32'd1);
    assign w_cmp_idx  = 5'(32'(r_n) - 32'(CHAIN_LEN));

    // Returning preamble is checked in whatever phase it reaches the tail.
    assign w_cmp_en   = r_shift_en && (32'(r_n) >= 32'(CHAIN_LEN)) &&
                        (32'(r_n) < 32'(c_TOTAL));
    assign w_mismatch = w_cmp_en && (ccff_tail != PREAMBLE[w_cmp_idx]);

    always_comb begin
        if (32'(r_rem) >= 32'(WORD_W)) begin
            w_take = c_C_W'(WORD_W);
        end else begin
            w_take = c_C_W'(r_rem);
        end
    end

    // State register
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start)     w_state_nxt = c_ST_PRE;
            c_ST_PRE:  if (w_pre_end) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: if (w_last)    w_state_nxt = c_ST_FIN;
            c_ST_FIN:                 w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (r_state != c_ST_IDLE) begin
            busy = 1'b1;
        end
        if (r_state == c_ST_FIN) begin
            done = 1'b1;
        end
        // In PRE a word is only taken on the last preamble shift so its bit 0
        // lands on ccff_head in the very next cycle.
        if (r_rem != '0) begin
            cfg_ready = ((r_state == c_ST_LOAD) && w_buf_free) || w_pre_end;
        end
    end

    // Datapath: shift counter, word buffer, registered chain outputs
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_n        <= '0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_error <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_shift_en <= 1'b0;
                    if (start) begin
                        r_error    <= 1'b0;
                        r_n        <= '0;
                        r_cnt      <= '0;
                        r_rem      <= c_R_W'(CHAIN_LEN);
                        r_head     <= PREAMBLE[0];
                        r_shift_en <= 1'b1;
                    end
                end
                c_ST_PRE: begin
                    r_n <= r_n + c_N_W'(1);
                    if (w_pre_end) begin
                        r_shift_en <= 1'b0;
                    end else begin
                        r_head <= PREAMBLE[w_pre_idx];
                    end
                end
                c_ST_LOAD: begin
                    if (r_shift_en) begin
                        r_n <= r_n + c_N_W'(1);
                        if (w_last) begin
                            r_n        <= '0;
                            r_cnt      <= '0;
                            r_shift_en <= 1'b0;
                        end else if (r_cnt > c_C_W'(1)) begin
                            r_head <= r_buf[0];
                            r_buf  <= r_buf >> 1;
                            r_cnt  <= r_cnt - c_C_W'(1);
                        end else begin
                            r_cnt      <= '0;
                            r_shift_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_shift_en <= 1'b0;
                end
            endcase
            // A new word overrides the stall/empty decisions above.
            if (w_accept) begin
                r_head     <= cfg_data[0];
                r_buf      <= cfg_data >> 1;
                r_cnt      <= w_take;
                r_rem      <= r_rem - c_R_W'(w_take);
                r_shift_en <= 1'b1;
            end
        end
    end

    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Scoreboard bench for ccff_chain_loader with 20- and 4-flop
//               chain models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    typedef struct {
        logic [31:0] chain;
        logic        err;
        int          shifts;
        int          sh_base;
        int          words;
        int          acc_base;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       p_reset;
    logic       start_a, start_b;
    logic       valid_a, valid_b;
    logic [7:0] data_a, data_b;
    logic       force_a;
    logic       w_ready_a, w_head_a, w_se_a, w_busy_a, w_done_a, w_err_a;
    logic       w_ready_b, w_head_b, w_se_b, w_busy_b, w_done_b, w_err_b;
    logic       w_tail_a, w_tail_b;

    logic [19:0] r_chain_a = '0;
    logic [3:0]  r_chain_b = '0;
    logic [19:0] snap;
    logic [7:0]  words [4] = '{8'h3C, 8'h5A, 8'h0F, 8'hFF};

    int cyc = 0, sh_a = 0, sh_b = 0, acc_a = 0, acc_b = 0;
    int abase_a = 0, abase_b = 0, idx_a, idx_b;
    int n_checks = 0, n_fail = 0;
    exp_t q_a[$], q_b[$];

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .PRE_LEN(8), .PREAMBLE(32'hA5)) u_dut_a (
        .prog_clk(clk), .pReset(p_reset), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(w_ready_a), .ccff_head(w_head_a),
        .ccff_shift_en(w_se_a), .ccff_tail(w_tail_a), .busy(w_busy_a),
        .done(w_done_a), .error(w_err_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8), .PRE_LEN(8), .PREAMBLE(32'hA5)) u_dut_b (
        .prog_clk(clk), .pReset(p_reset), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(w_ready_b), .ccff_head(w_head_b),
        .ccff_shift_en(w_se_b), .ccff_tail(w_tail_b), .busy(w_busy_b),
        .done(w_done_b), .error(w_err_b)
    );

    assign w_tail_a = force_a ? 1'b0 : r_chain_a[0];
    assign w_tail_b = r_chain_b[0];

    always_comb begin
        idx_a  = acc_a - abase_a;
        idx_b  = acc_b - abase_b;
        data_a = (idx_a >= 0 && idx_a < 4) ? words[idx_a] : 8'hFF;
        data_b = (idx_b >= 0 && idx_b < 4) ? words[idx_b] : 8'hFF;
    end

    // Chain models, cycle/shift/accept counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_se_a) begin
            r_chain_a <= {w_head_a, r_chain_a[19:1]};
            sh_a      <= sh_a + 1;
        end
        if (w_se_b) begin
            r_chain_b <= {w_head_b, r_chain_b[3:1]};
            sh_b      <= sh_b + 1;
        end
        if (valid_a && w_ready_a) acc_a <= acc_a + 1;
        if (valid_b && w_ready_b) acc_b <= acc_b + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [31:0] chain,
                              input int sh, input int acc, input logic err);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        chk({tag, "_shift_count"}, 32'(sh - e.sh_base), 32'(e.shifts));
        chk({tag, "_words_taken"}, 32'(acc - e.acc_base), 32'(e.words));
        chk({tag, "_chain"}, chain, e.chain);
        chk({tag, "_error"}, {31'b0, err}, {31'b0, e.err});
    endtask

    // Monitor: every done pulse must match the oldest outstanding load
    always @(negedge clk) begin
        if (w_done_a) begin
            chk("a_done_expected", {31'b0, (q_a.size() != 0)}, 32'd1);
            if (q_a.size() != 0) check_done("a", q_a.pop_front(), 32'(r_chain_a), sh_a, acc_a, w_err_a);
        end
        if (w_done_b) begin
            chk("b_done_expected", {31'b0, (q_b.size() != 0)}, 32'd1);
            if (q_b.size() != 0) check_done("b", q_b.pop_front(), 32'(r_chain_b), sh_b, acc_b, w_err_b);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic launch(input bit go_a, input bit go_b, input bit push_a,
                          input int lat_a, input logic err_a, output int c0);
        exp_t e;
        c0 = cyc;
        if (go_a) begin
            start_a = 1'b1;
            abase_a = acc_a;
            if (push_a) begin
                e.chain = 32'h000F5A3C; e.err = err_a; e.shifts = 28; e.sh_base = sh_a;
                e.words = 3; e.acc_base = acc_a; e.done_cyc = c0 + lat_a;
                q_a.push_back(e);
            end
        end
        if (go_b) begin
            start_b = 1'b1;
            abase_b = acc_b;
            e.chain = 32'h0000000C; e.err = 1'b0; e.shifts = 12; e.sh_base = sh_b;
            e.words = 1; e.acc_base = acc_b; e.done_cyc = c0 + 13;
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_pending", 32'(q_a.size() + q_b.size()), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int c0;
        p_reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        valid_a = 1'b1; valid_b = 1'b1; force_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", {26'b0, w_head_a, w_se_a, w_ready_a, w_busy_a, w_done_a, w_err_a}, 32'd0);
        chk("rst_outs_b", {26'b0, w_head_b, w_se_b, w_ready_b, w_busy_b, w_done_b, w_err_b}, 32'd0);
        @(posedge clk); #1;
        p_reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle_ready_a", {31'b0, w_ready_a}, 32'd0);
        chk("idle_busy_a", {31'b0, w_busy_a}, 32'd0);
        @(posedge clk); #1;

        // Basic load on both chains together
        launch(1'b1, 1'b1, 1'b1, 29, 1'b0, c0);
        @(negedge clk);
        chk("first_shift_a", {29'b0, w_busy_a, w_se_a, w_head_a}, 32'h7);
        chk("first_shift_b", {29'b0, w_busy_b, w_se_b, w_head_b}, 32'h7);
        drain();

        // Stall: second word withheld, five idle shift cycles
        launch(1'b1, 1'b0, 1'b1, 34, 1'b0, c0);
        wait_until(c0 + 9);
        valid_a = 1'b0;
        for (int k = 17; k <= 21; k++) begin
            wait_until(c0 + k);
            if (k == 21) valid_a = 1'b1;
            @(negedge clk);
            chk("stall_shift_en", {31'b0, w_se_a}, 32'd0);
            if (k == 17) begin
                snap = r_chain_a;
                chk("stall_ready", {31'b0, w_ready_a}, 32'd1);
            end else begin
                chk("stall_chain_hold", 32'(r_chain_a), 32'(snap));
            end
        end
        drain();

        // Broken chain, plus a start pulse while busy after the error
        force_a = 1'b1;
        launch(1'b1, 1'b0, 1'b1, 29, 1'b1, c0);
        wait_until(c0 + 21);
        @(negedge clk);
        chk("brk_err_before", {31'b0, w_err_a}, 32'd0);
        wait_until(c0 + 22);
        @(negedge clk);
        chk("brk_err_set", {31'b0, w_err_a}, 32'd1);
        wait_until(c0 + 25);
        start_a = 1'b1;
        wait_until(c0 + 26);
        start_a = 1'b0;
        @(negedge clk);
        chk("brk_err_kept", {31'b0, w_err_a}, 32'd1);
        drain();
        @(negedge clk);
        chk("brk_err_sticky", {31'b0, w_err_a}, 32'd1);
        force_a = 1'b0;
        @(posedge clk); #1;

        // Reset at n=10, then a full load
        launch(1'b1, 1'b0, 1'b0, 0, 1'b0, c0);
        @(negedge clk);
        chk("err_cleared_by_start", {31'b0, w_err_a}, 32'd0);
        wait_until(c0 + 11);
        p_reset = 1'b1;
        wait_until(c0 + 12);
        @(negedge clk);
        chk("midrst_outs", {26'b0, w_head_a, w_se_a, w_ready_a, w_busy_a, w_done_a, w_err_a}, 32'd0);
        wait_until(c0 + 13);
        p_reset = 1'b0;
        @(posedge clk); #1;
        launch(1'b1, 1'b0, 1'b1, 29, 1'b0, c0);
        drain();

        // Start pulsed at n=5 must not disturb the load
        launch(1'b1, 1'b0, 1'b1, 29, 1'b0, c0);
        wait_until(c0 + 6);
        start_a = 1'b1;
        wait_until(c0 + 7);
        start_a = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
